time_of_day_counter: RTL and testbench

//  Receiving end of the divided slow clock: samples the 1 Hz (or sped-up) square wave from the

---
 rtl/clock_pkg.sv | 18 +
 rtl/tick_sync.sv | 34 +++
 rtl/time_of_day_counter.sv | 117 +++++++++++
 tb/tb_time_of_day_counter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and limits for the time-of-day counter.
package clock_pkg;

    typedef struct packed {
        logic [4:0] hr;
        logic [5:0] min;
        logic [5:0] sec;
    } time_t;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/tick_sync.sv
// Synchronizes the divided square wave into clk_i and emits a one-cycle tick per rising edge.
module tick_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_clk_i,
    output logic tick_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   fill_q;
    logic                   prev_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // fill_q marks when prev_q holds a real sampled level, so a wave already
    // high when reset releases is taken as the baseline rather than an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            fill_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick_clk_i};
            fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            prev_q <= synced;
        end
    end

    assign tick_o = fill_q[SYNC_STAGES] & synced & ~prev_q;

endmodule

// File: rtl/time_of_day_counter.sv
// Hours:minutes:seconds counter advanced by synchronized second ticks, with a time-set handshake.
// Handshake: a set transfers on a clk_in edge where set_valid & set_ready; set_valid seen while set_ready=0 is ignored.
module time_of_day_counter
    import clock_pkg::*;
#(
    parameter int HOURS_PER_DAY = 24,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tick_clk,
    input  logic       run_en,
    input  logic       set_valid,
    output logic       set_ready,
    input  logic [4:0] set_hr,
    input  logic [5:0] set_min,
    input  logic [5:0] set_sec,
    output logic       set_error,
    output logic [4:0] hr,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       sec_pulse,
    output logic       min_wrap,
    output logic       day_wrap,
    output state_e     state_dbg_o
);

    localparam logic [4:0] HR_LIMIT = 5'(HOURS_PER_DAY);
    localparam logic [4:0] HR_MAX   = 5'(HOURS_PER_DAY - 1);

    state_e state_q, state_d;
    time_t  time_q, time_d;
    logic   sec_pulse_q, sec_pulse_d;
    logic   min_wrap_q, min_wrap_d;
    logic   day_wrap_q, day_wrap_d;
    logic   set_error_q, set_error_d;
    logic   tick;
    logic   set_fire;
    logic   set_legal;

    tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tick_sync (
        .clk_i      (clk_in),
        .rst_i      (reset),
        .tick_clk_i (tick_clk),
        .tick_o     (tick)
    );

    assign set_ready = (state_q == RUN);
    assign set_fire  = set_valid & set_ready;
    assign set_legal = (set_hr < HR_LIMIT) && (set_min <= MIN_MAX) && (set_sec <= SEC_MAX);

    always_comb begin
        state_d     = RUN;
        time_d      = time_q;
        sec_pulse_d = 1'b0;
        min_wrap_d  = 1'b0;
        day_wrap_d  = 1'b0;
        set_error_d = 1'b0;
        // A set in the same cycle as a tick wins; that tick is lost.
        if (set_fire) begin
            if (set_legal) begin
                time_d.hr  = set_hr;
                time_d.min = set_min;
                time_d.sec = set_sec;
            end else begin
                set_error_d = 1'b1;
            end
        end else if (tick && run_en && (state_q == RUN)) begin
            sec_pulse_d = 1'b1;
            if (time_q.sec == SEC_MAX) begin
                time_d.sec = '0;
                min_wrap_d = 1'b1;
                if (time_q.min == MIN_MAX) begin
                    time_d.min = '0;
                    if (time_q.hr == HR_MAX) begin
                        time_d.hr  = '0;
                        day_wrap_d = 1'b1;
                    end else begin
                        time_d.hr = time_q.hr + 5'd1;
                    end
                end else begin
                    time_d.min = time_q.min + 6'd1;
                end
            end else begin
                time_d.sec = time_q.sec + 6'd1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q     <= PRIME;
            time_q      <= '0;
            sec_pulse_q <= 1'b0;
            min_wrap_q  <= 1'b0;
            day_wrap_q  <= 1'b0;
            set_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            time_q      <= time_d;
            sec_pulse_q <= sec_pulse_d;
            min_wrap_q  <= min_wrap_d;
            day_wrap_q  <= day_wrap_d;
            set_error_q <= set_error_d;
        end
    end

    assign hr          = time_q.hr;
    assign min         = time_q.min;
    assign sec         = time_q.sec;
    assign sec_pulse   = sec_pulse_q;
    assign min_wrap    = min_wrap_q;
    assign day_wrap    = day_wrap_q;
    assign set_error   = set_error_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter: 24-hour instance plus a 12-hour instance for the wrap case.
module tb_time_of_day_counter;
    import clock_pkg::*;

    logic       clk_in = 1'b0;
    logic       reset, tick_clk, run_en, set_valid, set_valid2;
    logic [4:0] set_hr;
    logic [5:0] set_min, set_sec;
    logic       set_ready, set_error, sec_pulse, min_wrap, day_wrap;
    logic [4:0] hr;
    logic [5:0] min, sec;
    state_e     st;
    logic       set_ready2, set_error2, sec_pulse2, min_wrap2, day_wrap2;
    logic [4:0] hr2;
    logic [5:0] min2, sec2;
    state_e     st2;

    int n_checks = 0;
    int n_fails  = 0;
    logic [19:0] exp_q[$];
    int m_hr, m_min, m_sec;

    always #10 clk_in = ~clk_in;

    time_of_day_counter #(.HOURS_PER_DAY(24), .SYNC_STAGES(2)) dut (
        .clk_in(clk_in), .reset(reset), .tick_clk(tick_clk), .run_en(run_en),
        .set_valid(set_valid), .set_ready(set_ready), .set_hr(set_hr), .set_min(set_min),
        .set_sec(set_sec), .set_error(set_error), .hr(hr), .min(min), .sec(sec),
        .sec_pulse(sec_pulse), .min_wrap(min_wrap), .day_wrap(day_wrap), .state_dbg_o(st)
    );

    time_of_day_counter #(.HOURS_PER_DAY(12), .SYNC_STAGES(2)) dut12 (
        .clk_in(clk_in), .reset(reset), .tick_clk(tick_clk), .run_en(run_en),
        .set_valid(set_valid2), .set_ready(set_ready2), .set_hr(set_hr), .set_min(set_min),
        .set_sec(set_sec), .set_error(set_error2), .hr(hr2), .min(min2), .sec(sec2),
        .sec_pulse(sec_pulse2), .min_wrap(min_wrap2), .day_wrap(day_wrap2), .state_dbg_o(st2)
    );

    function automatic logic [19:0] obs_vec();
        return {hr, min, sec, min_wrap, day_wrap, set_error};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model works in seconds-of-day, independent of field-wise carries.
    task automatic model_tick();
        int t;
        logic mw, dw;
        t = (m_hr * 3600 + m_min * 60 + m_sec + 1) % (24 * 3600);
        m_hr  = t / 3600;
        m_min = (t / 60) % 60;
        m_sec = t % 60;
        mw = (m_sec == 0);
        dw = (t == 0);
        exp_q.push_back({5'(m_hr), 6'(m_min), 6'(m_sec), mw, dw, 1'b0});
    endtask

    task automatic pop_check(input string tag);
        logic [19:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'(obs_vec()), 32'(e));
        end
    endtask

    // One full tick_clk period of 20 clk_in cycles: high 10, low 10.
    task automatic do_tick(input bit chk12);
        int seen, first;
        bit expect_p;
        expect_p = run_en;
        if (expect_p) model_tick();
        seen = 0;
        first = 0;
        @(posedge clk_in); #1 tick_clk = 1'b1;
        for (int n = 1; n <= 19; n++) begin
            @(posedge clk_in); #1;
            if (n == 10) tick_clk = 1'b0;
            @(negedge clk_in);
            if (sec_pulse) begin
                seen++;
                if (first == 0) first = n;
            end
            if (n == 3 && expect_p) pop_check("tick_state");
            if (n == 3 && chk12)
                check("h12_wrap", {hr2, min2, sec2, min_wrap2, day_wrap2}, {5'd0, 6'd0, 6'd0, 1'b1, 1'b1});
        end
        check("tick_pulses", seen, expect_p ? 1 : 0);
        if (expect_p) check("tick_latency", first, 3);
        else check("frozen_time", {hr, min, sec}, {5'(m_hr), 6'(m_min), 6'(m_sec)});
    endtask

    task automatic do_set(input int h, input int m, input int s);
        bit legal;
        legal = (h < 24) && (m < 60) && (s < 60);
        check("set_ready", set_ready, 1);
        if (legal) begin
            m_hr = h; m_min = m; m_sec = s;
            exp_q.push_back({5'(h), 6'(m), 6'(s), 3'b000});
        end else begin
            exp_q.push_back({5'(m_hr), 6'(m_min), 6'(m_sec), 3'b001});
        end
        @(posedge clk_in); #1;
        set_valid = 1'b1; set_hr = 5'(h); set_min = 6'(m); set_sec = 6'(s);
        @(posedge clk_in); #1 set_valid = 1'b0;
        @(negedge clk_in);
        pop_check("set_result");
        check("set_no_pulse", sec_pulse, 0);
        @(negedge clk_in);
        check("set_error_clear", set_error, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        reset = 1'b1; tick_clk = 1'b1; run_en = 1'b1;
        set_valid = 1'b0; set_valid2 = 1'b0;
        set_hr = '0; set_min = '0; set_sec = '0;
        m_hr = 0; m_min = 0; m_sec = 0;

        // 1: tick_clk high through reset release is not a tick
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("reset_outputs", obs_vec(), 20'd0);
        check("reset_flags", {sec_pulse, set_ready, st}, 3'b000);
        @(posedge clk_in); #1 reset = 1'b0;
        @(negedge clk_in);
        check("prime_not_ready", set_ready, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            if (sec_pulse) seen++;
        end
        check("no_pulse_high_at_reset", seen, 0);
        check("time_after_release", {hr, min, sec}, 17'd0);
        check("run_state", {set_ready, st}, {1'b1, RUN});
        @(posedge clk_in); #1 tick_clk = 1'b0;
        repeat (9) @(posedge clk_in);

        // 2: three ticks
        for (int i = 0; i < 3; i++) do_tick(1'b0);
        check("three_ticks", {hr, min, sec}, {5'd0, 6'd0, 6'd3});

        // 3: day wrap, then 12-hour wrap on the second instance
        do_set(23, 59, 58);
        do_tick(1'b0);
        do_tick(1'b0);
        @(posedge clk_in); #1;
        set_valid2 = 1'b1; set_hr = 5'd11; set_min = 6'd59; set_sec = 6'd59;
        @(posedge clk_in); #1 set_valid2 = 1'b0;
        @(negedge clk_in);
        check("h12_set", {hr2, min2, sec2, set_error2}, {5'd11, 6'd59, 6'd59, 1'b0});
        do_tick(1'b1);

        // 4: illegal then legal set
        do_set(3, 60, 0);
        do_set(12, 34, 56);
        do_set(24, 0, 0);

        // 5: set collides with tick; then run_en low
        do_set(0, 0, 5);
        m_hr = 1; m_min = 0; m_sec = 0;
        exp_q.push_back({5'd1, 6'd0, 6'd0, 3'b000});
        @(posedge clk_in); #1 tick_clk = 1'b1;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        set_valid = 1'b1; set_hr = 5'd1; set_min = 6'd0; set_sec = 6'd0;
        @(posedge clk_in); #1 set_valid = 1'b0;
        @(negedge clk_in);
        pop_check("set_beats_tick");
        seen = sec_pulse ? 1 : 0;
        for (int n = 4; n <= 19; n++) begin
            @(posedge clk_in); #1;
            if (n == 10) tick_clk = 1'b0;
            @(negedge clk_in);
            if (sec_pulse) seen++;
        end
        check("collide_no_pulse", seen, 0);
        run_en = 1'b0;
        for (int i = 0; i < 4; i++) do_tick(1'b0);
        run_en = 1'b1;
        do_tick(1'b0);

        // 6: asynchronous reset mid-count
        do_set(0, 12, 34);
        do_tick(1'b0);
        @(posedge clk_in); #5 reset = 1'b1;
        #1;
        check("async_reset_time", {hr, min, sec}, 17'd0);
        check("async_reset_flags", {sec_pulse, set_ready, st}, 3'b000);
        m_hr = 0; m_min = 0; m_sec = 0;
        repeat (3) @(posedge clk_in);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("resume_ready", {set_ready, st}, {1'b1, RUN});
        do_tick(1'b0);
        check("resume_count", {hr, min, sec}, {5'd0, 6'd0, 6'd1});

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
